// File: rtl/hw_prefetch_queue_pkg.sv
// Shared widths, defaults and the queued-parcel layout for the half-word prefetch queue.
package hw_prefetch_queue_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned PARCEL_W      = 16;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Pointer width for a power-of-two FIFO; never below one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [PARCEL_W-1:0] data;
    } parcel_t;

endpackage

// File: rtl/hw_parcel_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; head is read combinationally.
module hw_parcel_fifo
    import hw_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = $bits(parcel_t)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head_c,
    output logic [ptr_w(DEPTH):0]    count,
    output logic                     empty_c
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty_c;
    assign head_c  = mem[rd_ptr];

    // Flush outranks push and pop; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hw_prefetch_queue.sv
// Half-word prefetch: sequential I-cache requests, parcel buffering, jump redirect and flush.
module hw_prefetch_queue
    import hw_prefetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jump,
    input  logic [XLEN-1:0]     jump_target,
    output logic                ic_req,
    output logic [XLEN-1:0]     ic_addr,
    input  logic                ic_stall,
    input  logic [PARCEL_W-1:0] ic_rdata,
    output logic [PARCEL_W-1:0] hw_o,
    output logic [XLEN-1:0]     hw_pc_o,
    output logic                hw_valid_o,
    input  logic                hw_pop_i,
    output logic                fetch_stall_o
);

    localparam int unsigned CW = ptr_w(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    parcel_t         wr_parcel;
    parcel_t         head;

    // Request depends only on registered occupancy plus the jump pulse, never on pop/stall.
    assign ic_req  = rst_n && (fifo_count < CW'(DEPTH)) && !jump;
    assign ic_addr = fetch_pc;
    assign push    = ic_req && !ic_stall;
    assign pop     = hw_pop_i && hw_valid_o;

    assign wr_parcel = '{pc: fetch_pc, data: ic_rdata};

    hw_parcel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(parcel_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (jump),
        .wdata   (wr_parcel),
        .head_c  (head),
        .count   (fifo_count),
        .empty_c (fifo_empty)
    );

    assign hw_valid_o    = !fifo_empty;
    assign fetch_stall_o = fifo_empty;
    assign hw_o          = fifo_empty ? '0 : head.data;
    assign hw_pc_o       = fifo_empty ? '0 : head.pc;

    // Jump redirect wins over sequential advance; bit 0 is always cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC & ~XLEN'(1);
        end else if (jump) begin
            fetch_pc <= jump_target & ~XLEN'(1);
        end else if (push) begin
            fetch_pc <= fetch_pc + XLEN'(2);
        end
    end

endmodule

// File: tb/tb_hw_prefetch_queue.sv
// Directed table-driven bench for hw_prefetch_queue with hand-written stream, wrap and reset sequences.
module tb_hw_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        jump;
    logic [31:0] jump_target;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_stall;
    logic [15:0] ic_rdata;
    logic [15:0] hw_o;
    logic [31:0] hw_pc_o;
    logic        hw_valid_o;
    logic        hw_pop_i;
    logic        fetch_stall_o;

    int n_checks;
    int n_fail;

    hw_prefetch_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump          (jump),
        .jump_target   (jump_target),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_stall      (ic_stall),
        .ic_rdata      (ic_rdata),
        .hw_o          (hw_o),
        .hw_pc_o       (hw_pc_o),
        .hw_valid_o    (hw_valid_o),
        .hw_pop_i      (hw_pop_i),
        .fetch_stall_o (fetch_stall_o)
    );

    // Cache model: parcel content is the half-word index of its address.
    assign ic_rdata = ic_addr[16:1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        jump;
        logic [31:0] target;
        logic        stall;
        logic        pop;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [15:0] hw;
        logic [31:0] pc;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic r, logic j, logic [31:0] t, logic s, logic p,
                                logic q, logic [31:0] a, logic val, logic [15:0] h,
                                logic [31:0] pc);
        vec_t x;
        x.rst_n = r; x.jump = j; x.target = t; x.stall = s; x.pop = p;
        x.req = q; x.addr = a; x.valid = val; x.hw = h; x.pc = pc;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic j, input logic [31:0] t,
                         input logic s, input logic p);
        @(negedge clk);
        rst_n = r; jump = j; jump_target = t; ic_stall = s; hw_pop_i = p;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; jump = 1'b0; jump_target = '0; ic_stall = 1'b0; hw_pop_i = 1'b0;
        repeat (2) @(posedge clk);

        //          rst jmp target        stl pop | req addr          vld hw        pc
        tbl[0]  = mk(0, 0, 32'h0,        0, 0,    0, 32'h0,        0, 16'h0,    32'h0);
        tbl[1]  = mk(1, 0, 32'h0,        0, 0,    1, 32'h0,        0, 16'h0,    32'h0);
        tbl[2]  = mk(1, 0, 32'h0,        0, 0,    1, 32'h2,        1, 16'h0,    32'h0);
        tbl[3]  = mk(1, 0, 32'h0,        0, 0,    1, 32'h4,        1, 16'h0,    32'h0);
        tbl[4]  = mk(1, 0, 32'h0,        0, 0,    1, 32'h6,        1, 16'h0,    32'h0);
        tbl[5]  = mk(1, 0, 32'h0,        0, 0,    0, 32'h8,        1, 16'h0,    32'h0);
        tbl[6]  = mk(1, 0, 32'h0,        0, 1,    0, 32'h8,        1, 16'h0,    32'h0);
        tbl[7]  = mk(1, 0, 32'h0,        0, 1,    1, 32'h8,        1, 16'h1,    32'h2);
        tbl[8]  = mk(1, 1, 32'h103,      0, 1,    0, 32'hA,        1, 16'h2,    32'h4);
        tbl[9]  = mk(1, 0, 32'h0,        0, 0,    1, 32'h102,      0, 16'h0,    32'h0);
        tbl[10] = mk(1, 1, 32'hC,        0, 0,    0, 32'h104,      1, 16'h81,   32'h102);
        tbl[11] = mk(1, 0, 32'h0,        0, 0,    1, 32'hC,        0, 16'h0,    32'h0);
        tbl[12] = mk(1, 0, 32'h0,        0, 0,    1, 32'hE,        1, 16'h6,    32'hC);
        tbl[13] = mk(1, 0, 32'h0,        1, 1,    1, 32'h10,       1, 16'h6,    32'hC);
        tbl[14] = mk(1, 0, 32'h0,        1, 1,    1, 32'h10,       1, 16'h7,    32'hE);
        tbl[15] = mk(1, 0, 32'h0,        1, 1,    1, 32'h10,       0, 16'h0,    32'h0);
        tbl[16] = mk(1, 0, 32'h0,        0, 0,    1, 32'h10,       0, 16'h0,    32'h0);
        tbl[17] = mk(1, 0, 32'h0,        1, 0,    1, 32'h12,       1, 16'h8,    32'h10);
        tbl[18] = mk(1, 0, 32'h0,        1, 1,    1, 32'h12,       1, 16'h8,    32'h10);
        tbl[19] = mk(1, 0, 32'h0,        1, 0,    1, 32'h12,       0, 16'h0,    32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst_n, tbl[i].jump, tbl[i].target, tbl[i].stall, tbl[i].pop);
            chk($sformatf("v%0d ic_req", i),     32'(ic_req),        32'(tbl[i].req));
            chk($sformatf("v%0d ic_addr", i),    ic_addr,            tbl[i].addr);
            chk($sformatf("v%0d hw_valid", i),   32'(hw_valid_o),    32'(tbl[i].valid));
            chk($sformatf("v%0d fetch_stall", i), 32'(fetch_stall_o), 32'(!tbl[i].valid));
            chk($sformatf("v%0d hw_o", i),       32'(hw_o),          32'(tbl[i].hw));
            chk($sformatf("v%0d hw_pc", i),      hw_pc_o,            tbl[i].pc);
        end

        // Steady stream: one push and one pop per cycle after a redirect to 0.
        for (int k = 0; k < 66; k++) begin
            drive(1'b1, k == 0, 32'h0, 1'b0, 1'b1);
            if (k >= 2) begin
                chk($sformatf("stream%0d valid", k), 32'(hw_valid_o), 32'd1);
                chk($sformatf("stream%0d hw_o", k),  32'(hw_o),       32'(k - 2));
                chk($sformatf("stream%0d hw_pc", k), hw_pc_o,         32'(2 * (k - 2)));
            end
        end

        // Address wrap at the top of the 32-bit space.
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap full ic_req", 32'(ic_req), 32'd0);
        chk("wrap ic_addr", ic_addr, 32'h4);
        chk("wrap pc0", hw_pc_o, 32'hFFFF_FFFC);
        chk("wrap hw0", 32'(hw_o), 32'hFFFE);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap pc1", hw_pc_o, 32'hFFFF_FFFE);
        chk("wrap hw1", 32'(hw_o), 32'hFFFF);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap pc2", hw_pc_o, 32'h0);
        chk("wrap hw2", 32'(hw_o), 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap pc3", hw_pc_o, 32'h2);
        chk("wrap hw3", 32'(hw_o), 32'h1);

        // Reset while parcels are queued.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst cycle ic_req", 32'(ic_req), 32'd0);
        chk("rst cycle still valid", 32'(hw_valid_o), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst valid cleared", 32'(hw_valid_o), 32'd0);
        chk("rst ic_addr", ic_addr, 32'h0);
        chk("rst hw_pc", hw_pc_o, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("post-rst ic_req", 32'(ic_req), 32'd1);
        chk("post-rst ic_addr", ic_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
